inst_fetch_responder: RTL and testbench
=======================================

INST_FETCH_RESPONDER -- requirements
Module: inst_fetch_responder

Interface
REQ-001 Parameter QDepth, default 4, meaning: entries in the accepted-request queue and in the in-flight queue (power of two, 2..16).
REQ-002 Parameter DataWidth, default 64, meaning: returned fetch word width (two 32-bit instructions).
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 request_i  input  1  fetch request from the PC unit; the address is valid in the same cycle.
REQ-006 addr_i  input  32  fetch address.
REQ-007 jumpFlag_i  input  1  redirect/flush pulse.
REQ-008 ready_o  output  1  responder can accept a request this cycle.
REQ-009 dataOk_o  output  1  one-cycle pulse: data_o and dataAddr_o are valid.
REQ-010 data_o  output  DataWidth  fetched word.
REQ-011 dataAddr_o  output  32  addr_i of the request that produced data_o.
REQ-012 mem_req_o  output  1  memory read request.
REQ-013 mem_addr_o  output  32  memory read address, 8-byte aligned.
REQ-014 mem_gnt_i  input  1  memory accepts mem_req_o this cycle.
REQ-015 mem_rvalid_i  input  1  read data valid; responses return in grant order.
REQ-016 mem_rdata_i  input  DataWidth  read data.

Function
REQ-017 ready_o SHALL be 1 exactly when the request queue is not full; it is combinational from occupancy only.
REQ-018 A request SHALL be accepted when request_i=1 and ready_o=1; addr_i is pushed into the request queue.
REQ-019 mem_req_o SHALL equal "request queue not empty".
REQ-020 mem_addr_o SHALL be {head.addr[31:3],3'b000}.
REQ-021 On mem_req_o=1 and mem_gnt_i=1, the head entry SHALL move from the request queue to the in-flight queue in that cycle.
REQ-022 No grant SHALL be taken while the in-flight queue is full; mem_req_o is forced to 0 in that case.
REQ-023 On mem_rvalid_i=1, the in-flight head SHALL pop.
REQ-024 If the popped entry is live, the block SHALL register dataOk_o=1, data_o=mem_rdata_i and dataAddr_o=entry.addr for the next cycle (latency: rvalid to dataOk_o is 1 cycle).
REQ-025 dataOk_o SHALL be 0 in every cycle not covered by REQ-024; data_o and dataAddr_o hold their last values.
REQ-026 If the popped entry is stale, the response SHALL be discarded with no dataOk_o.
REQ-027 mem_rvalid_i while the in-flight queue is empty is a protocol error: it SHALL be ignored, with no pop and no dataOk_o.
REQ-028 On jumpFlag_i=1, the request queue SHALL be cleared, including any entry granted in that same cycle.
REQ-029 On jumpFlag_i=1, every in-flight entry (including one being popped in that cycle) SHALL be marked stale; a stale-discard counter is loaded with the in-flight count.
REQ-030 A request with request_i=1 in the jump cycle SHALL be accepted as the first post-flush entry (ready_o evaluated before the clear); it is never stale.
REQ-031 A response arriving in the jump cycle SHALL be dropped, and dataOk_o SHALL be 0 next cycle.
REQ-032 The stale counter SHALL decrement per discarded response.
REQ-033 A second jumpFlag_i while the stale counter is nonzero SHALL reload the counter with the total in-flight count.
REQ-034 Queue pointers SHALL be log2(QDepth)+1 bits wide with wrap-around; full and empty are decided by the MSB compare.
REQ-035 Simultaneous push and pop on the same queue SHALL leave occupancy unchanged and be legal when the queue is full.

Reset
REQ-036 While reset_n=0, the outputs SHALL be: dataOk_o=0, data_o=0, dataAddr_o=0, mem_req_o=0, ready_o=1 (after reset release); both queues empty; stale counter 0.
REQ-037 Reset asserted mid-transaction SHALL abandon all queued and in-flight state; responses arriving after release with no in-flight entry follow REQ-027.

Verification
REQ-038 Single fetch: request_i with addr 0x0000_0004, mem_gnt_i the same cycle, rvalid 2 cycles later with data 0xAAAA_BBBB_CCCC_DDDD -> mem_addr_o=0x0000_0000; one dataOk_o pulse with that data and dataAddr_o=0x0000_0004.
REQ-039 Back-pressure: mem_gnt_i held 0, QDepth=4, addresses 0x04,0x0C,0x14,0x1C,0x24 presented -> ready_o falls after 4 accepts; the fifth is not accepted; the fifth is accepted after the first grant.
REQ-040 Flush: 3 granted entries outstanding, jumpFlag_i with request_i addr 0x100 -> the next 3 rvalids produce no dataOk_o; the 4th response yields dataAddr_o=0x100.
REQ-041 Jump coincident with rvalid: 1 in flight, rvalid and jumpFlag_i in the same cycle -> no dataOk_o; the stale counter ends at 0; the next live response is delivered.
REQ-042 Streaming: grant every cycle, rvalid 1 cycle after grant, 16 sequential requests -> 16 in-order dataOk_o pulses, no loss, with ready_o staying 1.
REQ-043 Reset mid-stream: reset_n pulsed low with 2 in flight -> all outputs return to their reset values; later stray rvalids produce no dataOk_o.

Source files
------------

// File: rtl/inst_fetch_responder.sv
// Instruction fetch responder: queues PC-unit requests, issues aligned memory reads,
// and returns fetched words in order while discarding responses made stale by a jump.
module inst_fetch_responder #(
  parameter int unsigned QDepth    = 4,
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 request_i,
  input  logic [31:0]          addr_i,
  input  logic                 jumpFlag_i,
  output logic                 ready_o,
  output logic                 dataOk_o,
  output logic [DataWidth-1:0] data_o,
  output logic [31:0]          dataAddr_o,
  output logic                 mem_req_o,
  output logic [31:0]          mem_addr_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [DataWidth-1:0] mem_rdata_i
);

  localparam int unsigned AW = (QDepth > 1) ? $clog2(QDepth) : 1;
  localparam int unsigned PW = AW + 1;

  typedef logic [PW-1:0] ptr_t;

  ptr_t              rq_wr, rq_rd, if_wr, if_rd, stale_cnt;
  logic [31:0]       rq_addr [QDepth];
  logic [31:0]       if_addr [QDepth];
  logic [QDepth-1:0] if_live;

  logic [AW-1:0] rq_wr_idx, rq_rd_idx, if_wr_idx, if_rd_idx;
  logic          rq_empty, rq_full, if_empty, if_full;
  logic          rq_push, grant, if_pop, deliver, discard;
  ptr_t          if_count_next;

  assign rq_wr_idx = rq_wr[AW-1:0];
  assign rq_rd_idx = rq_rd[AW-1:0];
  assign if_wr_idx = if_wr[AW-1:0];
  assign if_rd_idx = if_rd[AW-1:0];

  // Full when the wrap bits differ and the index bits match.
  assign rq_empty = (rq_wr == rq_rd);
  assign rq_full  = (rq_wr[AW] != rq_rd[AW]) && (rq_wr_idx == rq_rd_idx);
  assign if_empty = (if_wr == if_rd);
  assign if_full  = (if_wr[AW] != if_rd[AW]) && (if_wr_idx == if_rd_idx);

  assign ready_o    = !rq_full;
  assign mem_req_o  = !rq_empty && !if_full;
  assign mem_addr_o = {rq_addr[rq_rd_idx][31:3], 3'b000};

  assign rq_push = request_i && ready_o;
  assign grant   = mem_req_o && mem_gnt_i;
  assign if_pop  = mem_rvalid_i && !if_empty;
  assign deliver = if_pop && if_live[if_rd_idx] && !jumpFlag_i;
  assign discard = if_pop && !deliver;

  assign if_count_next = (if_wr - if_rd) + PW'(grant) - PW'(if_pop);

  // Queue pointers, liveness and stale bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rq_wr     <= '0;
      rq_rd     <= '0;
      if_wr     <= '0;
      if_rd     <= '0;
      if_live   <= '0;
      stale_cnt <= '0;
    end else begin
      rq_wr <= rq_wr + PW'(rq_push);
      if (jumpFlag_i) begin
        rq_rd <= rq_wr;
      end else if (grant) begin
        rq_rd <= rq_rd + PW'(1);
      end
      if_wr <= if_wr + PW'(grant);
      if_rd <= if_rd + PW'(if_pop);
      if (jumpFlag_i) begin
        if_live <= '0;
      end
      if (grant) begin
        if_live[if_wr_idx] <= !jumpFlag_i;
      end
      if (jumpFlag_i) begin
        stale_cnt <= if_count_next;
      end else if (discard && (stale_cnt != '0)) begin
        stale_cnt <= stale_cnt - PW'(1);
      end
    end
  end

  // Address storage needs no reset; only pointer-covered entries are ever read.
  always_ff @(posedge clk) begin
    if (rq_push) begin
      rq_addr[rq_wr_idx] <= addr_i;
    end
    if (grant) begin
      if_addr[if_wr_idx] <= rq_addr[rq_rd_idx];
    end
  end

  // Registered response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dataOk_o   <= 1'b0;
      data_o     <= '0;
      dataAddr_o <= '0;
    end else begin
      dataOk_o <= deliver;
      if (deliver) begin
        data_o     <= mem_rdata_i;
        dataAddr_o <= if_addr[if_rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed testbench for inst_fetch_responder with hand-computed expectations.
module tb_inst_fetch_responder;

  logic        clk;
  logic        reset_n;
  logic        request_i;
  logic [31:0] addr_i;
  logic        jumpFlag_i;
  logic        ready_o;
  logic        dataOk_o;
  logic [63:0] data_o;
  logic [31:0] dataAddr_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;

  int vectors;
  int miscompares;

  inst_fetch_responder #(.QDepth(4), .DataWidth(64)) dut (
    .clk(clk), .reset_n(reset_n), .request_i(request_i), .addr_i(addr_i),
    .jumpFlag_i(jumpFlag_i), .ready_o(ready_o), .dataOk_o(dataOk_o), .data_o(data_o),
    .dataAddr_o(dataAddr_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    request_i    = 1'b0;
    jumpFlag_i   = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; idle(); addr_i = '0; mem_rdata_i = '0;
    tick(); tick();
    vectors++; if (dataOk_o !== 1'b0) begin miscompares++; $display("FAIL reset_ok got %0b want 0", dataOk_o); end
    vectors++; if (data_o !== 64'd0) begin miscompares++; $display("FAIL reset_data got %h want 0", data_o); end
    vectors++; if (dataAddr_o !== 32'd0) begin miscompares++; $display("FAIL reset_addr got %h want 0", dataAddr_o); end
    vectors++; if (mem_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_memreq got %0b want 0", mem_req_o); end
    reset_n = 1'b1;
    tick();
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %0b want 1", ready_o); end
  endtask

  task automatic test_single_fetch();
    request_i = 1'b1; addr_i = 32'h0000_0004;
    vectors++; if (mem_req_o !== 1'b0) begin miscompares++; $display("FAIL single_req0 got %0b want 0", mem_req_o); end
    tick();
    request_i = 1'b0; mem_gnt_i = 1'b1;
    vectors++; if (mem_req_o !== 1'b1) begin miscompares++; $display("FAIL single_req1 got %0b want 1", mem_req_o); end
    vectors++; if (mem_addr_o !== 32'h0) begin miscompares++; $display("FAIL single_maddr got %h want 0", mem_addr_o); end
    tick();
    mem_gnt_i = 1'b0;
    vectors++; if (mem_req_o !== 1'b0) begin miscompares++; $display("FAIL single_req2 got %0b want 0", mem_req_o); end
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'hAAAA_BBBB_CCCC_DDDD;
    vectors++; if (dataOk_o !== 1'b0) begin miscompares++; $display("FAIL single_early got %0b want 0", dataOk_o); end
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = 64'h0;
    vectors++; if (dataOk_o !== 1'b1) begin miscompares++; $display("FAIL single_ok got %0b want 1", dataOk_o); end
    vectors++; if (data_o !== 64'hAAAA_BBBB_CCCC_DDDD) begin miscompares++; $display("FAIL single_data got %h want aaaabbbbccccdddd", data_o); end
    vectors++; if (dataAddr_o !== 32'h4) begin miscompares++; $display("FAIL single_daddr got %h want 4", dataAddr_o); end
    tick();
    vectors++; if (dataOk_o !== 1'b0) begin miscompares++; $display("FAIL single_pulse got %0b want 0", dataOk_o); end
    vectors++; if (data_o !== 64'hAAAA_BBBB_CCCC_DDDD) begin miscompares++; $display("FAIL single_hold got %h want aaaabbbbccccdddd", data_o); end
  endtask

  task automatic test_back_pressure();
    logic [31:0] exp_addr [5];
    for (int i = 0; i < 5; i++) exp_addr[i] = 32'h4 + 32'(8 * i);
    for (int i = 0; i < 4; i++) begin
      request_i = 1'b1; addr_i = exp_addr[i];
      vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL bp_ready%0d got %0b want 1", i, ready_o); end
      tick();
    end
    addr_i = exp_addr[4];
    vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL bp_full got %0b want 0", ready_o); end
    vectors++; if (mem_addr_o !== 32'h0) begin miscompares++; $display("FAIL bp_head got %h want 0", mem_addr_o); end
    tick();
    vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL bp_full2 got %0b want 0", ready_o); end
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL bp_reopen got %0b want 1", ready_o); end
    vectors++; if (mem_addr_o !== 32'h8) begin miscompares++; $display("FAIL bp_head2 got %h want 8", mem_addr_o); end
    tick();
    request_i = 1'b0;
    vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL bp_fifth got %0b want 0", ready_o); end
    mem_gnt_i = 1'b1;
    for (int i = 1; i < 4; i++) begin
      vectors++; if (mem_addr_o !== {exp_addr[i][31:3], 3'b000}) begin miscompares++; $display("FAIL bp_maddr%0d got %h want %h", i, mem_addr_o, {exp_addr[i][31:3], 3'b000}); end
      tick();
    end
    vectors++; if (mem_req_o !== 1'b0) begin miscompares++; $display("FAIL bp_iffull got %0b want 0", mem_req_o); end
    for (int k = 0; k < 5; k++) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = 64'(100 + k);
      if (k > 0) begin
        vectors++; if (dataOk_o !== 1'b1 || dataAddr_o !== exp_addr[k-1] || data_o !== 64'(99 + k)) begin
          miscompares++; $display("FAIL bp_resp%0d got ok=%0b addr=%h data=%h want ok=1 addr=%h data=%h", k-1, dataOk_o, dataAddr_o, data_o, exp_addr[k-1], 64'(99 + k));
        end
      end
      tick();
    end
    idle();
    vectors++; if (dataOk_o !== 1'b1 || dataAddr_o !== exp_addr[4] || data_o !== 64'd104) begin
      miscompares++; $display("FAIL bp_resp4 got ok=%0b addr=%h data=%h want ok=1 addr=24 data=68", dataOk_o, dataAddr_o, data_o);
    end
    tick();
    vectors++; if (dataOk_o !== 1'b0) begin miscompares++; $display("FAIL bp_end got %0b want 0", dataOk_o); end
  endtask

  task automatic test_flush();
    mem_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      request_i = (i < 3); addr_i = 32'h200 + 32'(8 * i);
      tick();
    end
    mem_gnt_i = 1'b0; jumpFlag_i = 1'b1; request_i = 1'b1; addr_i = 32'h100;
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL flush_ready got %0b want 1", ready_o); end
    tick();
    jumpFlag_i = 1'b0; request_i = 1'b0; mem_gnt_i = 1'b1;
    vectors++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin miscompares++; $display("FAIL flush_head got req=%0b addr=%h want req=1 addr=100", mem_req_o, mem_addr_o); end
    tick();
    mem_gnt_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = 64'(k + 1);
      tick();
      mem_rvalid_i = 1'b0;
      vectors++; if (dataOk_o !== 1'b0) begin miscompares++; $display("FAIL flush_stale%0d got %0b want 0", k, dataOk_o); end
    end
    vectors++; if (dut.stale_cnt !== 3'd0) begin miscompares++; $display("FAIL flush_cnt got %0d want 0", dut.stale_cnt); end
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'h1234;
    tick();
    mem_rvalid_i = 1'b0;
    vectors++; if (dataOk_o !== 1'b1 || dataAddr_o !== 32'h100 || data_o !== 64'h1234) begin
      miscompares++; $display("FAIL flush_live got ok=%0b addr=%h data=%h want ok=1 addr=100 data=1234", dataOk_o, dataAddr_o, data_o);
    end
    tick();
  endtask

  task automatic test_jump_rvalid();
    request_i = 1'b1; addr_i = 32'h300;
    tick();
    request_i = 1'b0; mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; jumpFlag_i = 1'b1; mem_rdata_i = 64'h55;
    tick();
    mem_rvalid_i = 1'b0; jumpFlag_i = 1'b0;
    vectors++; if (dataOk_o !== 1'b0) begin miscompares++; $display("FAIL jr_drop got %0b want 0", dataOk_o); end
    vectors++; if (dut.stale_cnt !== 3'd0) begin miscompares++; $display("FAIL jr_cnt got %0d want 0", dut.stale_cnt); end
    request_i = 1'b1; addr_i = 32'h308;
    tick();
    request_i = 1'b0; mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h66;
    tick();
    vectors++; if (dataOk_o !== 1'b1 || dataAddr_o !== 32'h308 || data_o !== 64'h66) begin
      miscompares++; $display("FAIL jr_live got ok=%0b addr=%h data=%h want ok=1 addr=308 data=66", dataOk_o, dataAddr_o, data_o);
    end
    tick();
    mem_rvalid_i = 1'b0;
    vectors++; if (dataOk_o !== 1'b0) begin miscompares++; $display("FAIL jr_stray got %0b want 0", dataOk_o); end
  endtask

  task automatic test_streaming();
    mem_gnt_i = 1'b1;
    for (int c = 0; c <= 19; c++) begin
      request_i    = (c < 16);
      addr_i       = 32'h1004 + 32'(8 * c);
      mem_rvalid_i = (c >= 2) && (c < 18);
      mem_rdata_i  = 64'hD000_0000_0000_0000 | 64'(c - 2);
      vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL stream_ready%0d got %0b want 1", c, ready_o); end
      if (c >= 1 && c <= 16) begin
        vectors++; if (mem_addr_o !== 32'h1000 + 32'(8 * (c - 1))) begin miscompares++; $display("FAIL stream_maddr%0d got %h want %h", c, mem_addr_o, 32'h1000 + 32'(8 * (c - 1))); end
      end
      if (c >= 3 && c <= 18) begin
        vectors++; if (dataOk_o !== 1'b1 || dataAddr_o !== 32'h1004 + 32'(8 * (c - 3)) || data_o !== (64'hD000_0000_0000_0000 | 64'(c - 3))) begin
          miscompares++; $display("FAIL stream_resp%0d got ok=%0b addr=%h data=%h", c - 3, dataOk_o, dataAddr_o, data_o);
        end
      end else begin
        vectors++; if (dataOk_o !== 1'b0) begin miscompares++; $display("FAIL stream_idle%0d got %0b want 0", c, dataOk_o); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_midstream();
    mem_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      request_i = (i < 2); addr_i = 32'h400 + 32'(8 * i);
      tick();
    end
    idle();
    reset_n = 1'b0;
    #2;
    vectors++; if (dataOk_o !== 1'b0 || data_o !== 64'd0 || dataAddr_o !== 32'd0) begin
      miscompares++; $display("FAIL rst_out got ok=%0b data=%h addr=%h want 0/0/0", dataOk_o, data_o, dataAddr_o);
    end
    vectors++; if (mem_req_o !== 1'b0 || ready_o !== 1'b1) begin miscompares++; $display("FAIL rst_ctl got req=%0b ready=%0b want 0/1", mem_req_o, ready_o); end
    tick();
    reset_n = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'h77;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++; if (dataOk_o !== 1'b0) begin miscompares++; $display("FAIL rst_stray%0d got %0b want 0", k, dataOk_o); end
    end
    mem_rvalid_i = 1'b0;
    vectors++; if (dut.stale_cnt !== 3'd0) begin miscompares++; $display("FAIL rst_cnt got %0d want 0", dut.stale_cnt); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_fetch();
    test_back_pressure();
    test_flush();
    test_jump_rvalid();
    test_streaming();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
